// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_pkg: shared widths, FSM states and prefetch entry type for fetch.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package fetch_pkg;

    localparam int ADR_W  = 15;
    localparam int HW_W   = 16;
    localparam int INST_W = 32;

    typedef enum logic [0:0] {
        S_HI = 1'b0,
        S_LO = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADR_W-1:0]  pc;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/inst_fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_fetch_if: memory port B, redirect and decode handshake signals.     |
// | align_err exists only when FETCH_ALIGN_CHECK_EN is defined.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface inst_fetch_if;
    import fetch_pkg::*;

    logic              redirect;
    logic [ADR_W-1:0]  redirect_adr;
    logic [ADR_W-1:0]  mem_adr;
    logic [HW_W-1:0]   mem_dout;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADR_W-1:0]  inst_pc;
    logic              inst_ready;
`ifdef FETCH_ALIGN_CHECK_EN
    logic              align_err;
`endif

    modport master (
        input  redirect, redirect_adr, mem_dout, inst_ready,
`ifdef FETCH_ALIGN_CHECK_EN
        output align_err,
`endif
        output mem_adr, inst_valid, inst, inst_pc
    );

    modport slave (
        output redirect, redirect_adr, mem_dout, inst_ready,
`ifdef FETCH_ALIGN_CHECK_EN
        input  align_err,
`endif
        input  mem_adr, inst_valid, inst, inst_pc
    );

endinterface : inst_fetch_if
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_fifo: DEPTH-entry synchronous prefetch FIFO; flush beats push/pop. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     flush,
    input  wire logic                     push,
    input  wire fetch_entry_t             push_data,
    input  wire logic                     pop,
    output fetch_entry_t                  head,
    output logic                          valid,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop & valid;
    // Head is forced to zero when empty so the outputs read as reset values.
    assign head   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_fetch: two-halfword instruction fetch with prefetch FIFO/redirect.  |
// | Optional: FETCH_ALIGN_CHECK_EN adds the align_err pulse output.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int               DEPTH     = 2,
    parameter logic [ADR_W-1:0] START_ADR = 15'h0000
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    inst_fetch_if.master bus
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

    fetch_state_t      state, state_nxt;
    logic [ADR_W-1:0]  pc, pc_nxt;
    logic [ADR_W-1:0]  pend_pc, pend_pc_nxt;
    logic [HW_W-1:0]   hi_reg, hi_nxt;
    logic              pend_lo, pend_nxt;
    logic              push;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;
    logic              head_valid;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    reserved;

    assign bus.mem_adr    = (state == S_LO) ? pc + ADR_W'(1) : pc;
    assign bus.inst_valid = head_valid;
    assign bus.inst       = head.inst;
    assign bus.inst_pc    = head.pc;

    // Slots already filled plus the one instruction still waiting for its lo half.
    assign reserved = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pend_lo};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_HI;
            pc      <= START_ADR;
            pend_pc <= '0;
            hi_reg  <= '0;
            pend_lo <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            pend_pc <= pend_pc_nxt;
            hi_reg  <= hi_nxt;
            pend_lo <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        pend_pc_nxt     = pend_pc;
        hi_nxt          = hi_reg;
        pend_nxt        = pend_lo;
        push            = 1'b0;
        push_entry.inst = {hi_reg, bus.mem_dout};
        push_entry.pc   = pend_pc;

        if (pend_lo) begin
            push     = 1'b1;
            pend_nxt = 1'b0;
        end

        case (state)
            S_HI: begin
                if (reserved < DEPTH_C) begin
                    state_nxt = S_LO;
                end
            end
            S_LO: begin
                state_nxt   = S_HI;
                hi_nxt      = bus.mem_dout;
                pend_nxt    = 1'b1;
                pend_pc_nxt = pc;
                pc_nxt      = pc + ADR_W'(2);
            end
            default: state_nxt = S_HI;
        endcase

        // Redirect discards any half-assembled instruction and restarts at the target.
        if (bus.redirect) begin
            state_nxt = S_HI;
            pc_nxt    = bus.redirect_adr;
            pend_nxt  = 1'b0;
            push      = 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (bus.inst_ready),
        .head      (head),
        .valid     (head_valid),
        .count     (fifo_count)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic align_err_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            align_err_r <= 1'b0;
        end else begin
            align_err_r <= bus.redirect & bus.redirect_adr[0];
        end
    end

    assign bus.align_err = align_err_r;
`endif

endmodule : inst_fetch
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inst_fetch: directed self-checking bench for inst_fetch.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_inst_fetch;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    inst_fetch_if bus ();

    inst_fetch #(
        .DEPTH     (2),
        .START_ADR (15'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: four fixed halfwords at 0..3, everything else is addr ^ A5A5.
    function automatic logic [15:0] hw(input logic [14:0] a);
        case (a)
            15'h0000: hw = 16'h1234;
            15'h0001: hw = 16'h5678;
            15'h0002: hw = 16'h9ABC;
            15'h0003: hw = 16'hDEF0;
            default:  hw = {1'b0, a} ^ 16'hA5A5;
        endcase
    endfunction

    always @(posedge clk) bus.mem_dout <= hw(bus.mem_adr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_adr = '0;
        bus.inst_ready   = 1'b1;
        tick();
        tick();
        chk("rst_mem_adr", 64'(bus.mem_adr), 64'h0000);
        chk("rst_valid",   64'(bus.inst_valid), 64'd0);
        chk("rst_inst",    64'(bus.inst), 64'h0);
        chk("rst_pc",      64'(bus.inst_pc), 64'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_align",   64'(bus.align_err), 64'd0);
`endif

        // Basic fetch: first valid three edges after reset release.
        rst_n = 1'b1;
        tick();
        chk("e1_mem_adr", 64'(bus.mem_adr), 64'h0001);
        chk("e1_valid",   64'(bus.inst_valid), 64'd0);
        tick();
        chk("e2_valid",   64'(bus.inst_valid), 64'd0);
        tick();
        chk("e3_valid",   64'(bus.inst_valid), 64'd1);
        chk("e3_inst",    64'(bus.inst), 64'h12345678);
        chk("e3_pc",      64'(bus.inst_pc), 64'h0000);
        tick();
        chk("e4_valid",   64'(bus.inst_valid), 64'd0);
        tick();
        chk("e5_valid",   64'(bus.inst_valid), 64'd1);
        chk("e5_inst",    64'(bus.inst), 64'h9ABCDEF0);
        chk("e5_pc",      64'(bus.inst_pc), 64'h0002);

        // Stall: FIFO fills to DEPTH and fetch freezes at pc 0006.
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("stall_valid",   64'(bus.inst_valid), 64'd1);
        chk("stall_inst",    64'(bus.inst), 64'h9ABCDEF0);
        chk("stall_pc",      64'(bus.inst_pc), 64'h0002);
        chk("stall_mem_adr", 64'(bus.mem_adr), 64'h0006);
        bus.inst_ready = 1'b1;
        tick();
        chk("drain1_inst",    64'(bus.inst), 64'hA5A1A5A0);
        chk("drain1_pc",      64'(bus.inst_pc), 64'h0004);
        chk("drain1_mem_adr", 64'(bus.mem_adr), 64'h0006);
        tick();
        chk("drain2_valid",   64'(bus.inst_valid), 64'd0);
        chk("drain2_mem_adr", 64'(bus.mem_adr), 64'h0007);
        tick();
        chk("resume_mem_adr", 64'(bus.mem_adr), 64'h0008);
        tick();
        chk("resume_inst", 64'(bus.inst), 64'hA5A3A5A2);
        chk("resume_pc",   64'(bus.inst_pc), 64'h0006);
        chk("resume_lo",   64'(bus.mem_adr), 64'h0009);

        // Redirect while in S_LO with one entry buffered.
        bus.redirect     = 1'b1;
        bus.redirect_adr = 15'h0100;
        tick();
        bus.redirect = 1'b0;
        chk("redir_valid",   64'(bus.inst_valid), 64'd0);
        chk("redir_mem_adr", 64'(bus.mem_adr), 64'h0100);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("redir_even_align", 64'(bus.align_err), 64'd0);
`endif
        tick();
        chk("redir_e1_valid", 64'(bus.inst_valid), 64'd0);
        tick();
        chk("redir_e2_valid", 64'(bus.inst_valid), 64'd0);
        tick();
        chk("redir_inst", 64'(bus.inst), 64'hA4A5A4A4);
        chk("redir_pc",   64'(bus.inst_pc), 64'h0100);

        // Wrap-around fetch from 7FFF.
        bus.redirect     = 1'b1;
        bus.redirect_adr = 15'h7FFF;
        tick();
        bus.redirect = 1'b0;
        chk("wrap_mem_adr_hi", 64'(bus.mem_adr), 64'h7FFF);
        tick();
        chk("wrap_mem_adr_lo", 64'(bus.mem_adr), 64'h0000);
        tick();
        tick();
        chk("wrap_inst", 64'(bus.inst), 64'hDA5A1234);
        chk("wrap_pc",   64'(bus.inst_pc), 64'h7FFF);
        tick();
        tick();
        chk("wrap_next_inst", 64'(bus.inst), 64'h56789ABC);
        chk("wrap_next_pc",   64'(bus.inst_pc), 64'h0001);

        // Odd target: fetch proceeds from 0005.
        bus.redirect     = 1'b1;
        bus.redirect_adr = 15'h0005;
        tick();
        bus.redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("align_pulse", 64'(bus.align_err), 64'd1);
`endif
        tick();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("align_clear", 64'(bus.align_err), 64'd0);
`endif
        tick();
        tick();
        chk("odd_valid", 64'(bus.inst_valid), 64'd1);
        chk("odd_inst",  64'(bus.inst), 64'hA5A0A5A3);
        chk("odd_pc",    64'(bus.inst_pc), 64'h0005);
        tick();
        chk("odd_pop_valid", 64'(bus.inst_valid), 64'd0);

        // One-cycle reset while an instruction awaits its lo half.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_mem_adr", 64'(bus.mem_adr), 64'h0000);
        chk("mid_rst_valid",   64'(bus.inst_valid), 64'd0);
        chk("mid_rst_inst",    64'(bus.inst), 64'h0);
        chk("mid_rst_pc",      64'(bus.inst_pc), 64'h0);
        tick();
        chk("mid_rst_e1_valid", 64'(bus.inst_valid), 64'd0);
        tick();
        chk("mid_rst_e2_valid", 64'(bus.inst_valid), 64'd0);
        tick();
        chk("mid_rst_inst2", 64'(bus.inst), 64'h12345678);
        chk("mid_rst_pc2",   64'(bus.inst_pc), 64'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_inst_fetch
`default_nettype wire
